// File: rtl/jt49_pkg.sv
// ---------------------------------------------------------------------------
// jt49_pkg : bus codes, FSM states and helpers for the jt49 bus arbiter
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jt49_pkg;

  // {bdir, bc1} codes seen by the AY-3-8910 style bus
  localparam logic [1:0] BUS_INACT = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;
  localparam logic [1:0] BUS_ADDR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    GAP  = 3'd2,
    DATA = 3'd3,
    REC  = 3'd4
  } state_t;

  function automatic logic [1:0] data_code(input logic we);
    return we ? BUS_WRITE : BUS_READ;
  endfunction

  function automatic logic [7:0] data_bus(input logic we, input logic [7:0] wdata);
    return we ? wdata : 8'h00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jt49_bus_arb_if.sv
// ---------------------------------------------------------------------------
// jt49_bus_arb_if : requester handshakes plus the BDIR/BC1/DA chip bus
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface jt49_bus_arb_if;

  logic       r0_req;
  logic       r0_we;
  logic [3:0] r0_addr;
  logic [7:0] r0_wdata;
  logic       r0_ack;

  logic       r1_req;
  logic       r1_we;
  logic [3:0] r1_addr;
  logic [7:0] r1_wdata;
  logic       r1_ack;

  logic [7:0] rd_data;
  logic       busy;

  logic       bdir;
  logic       bc1;
  logic [7:0] da;
  logic [7:0] psg_dout;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  psg_dout,
    output r0_ack, r1_ack, rd_data, busy, bdir, bc1, da
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output psg_dout,
    input  r0_ack, r1_ack, rd_data, busy, bdir, bc1, da
  );

endinterface

`default_nettype wire

// File: rtl/jt49_rr_arb2.sv
// ---------------------------------------------------------------------------
// jt49_rr_arb2 : two-way round-robin arbiter, grants only while en is high
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jt49_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic rr_ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // after any grant the other requester wins the next tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (|gnt) begin
      rr_ptr <= gnt[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/jt49_bus_arb.sv
// ---------------------------------------------------------------------------
// jt49_bus_arb : shares and sequences one BDIR/BC1/DA bus for two requesters
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jt49_bus_arb
  import jt49_pkg::*;
#(
  parameter int unsigned PHASE_CYC = 2,
  parameter int unsigned GAP_CYC   = 1,
  parameter bit          SKIP_ADDR = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  jt49_bus_arb_if.slave  bus
);

  localparam logic [3:0] PHASE_LOAD = 4'(PHASE_CYC - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYC - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       sel, sel_n;
  logic       we_q, we_n;
  logic [3:0] addr_q, addr_n;
  logic [7:0] wdata_q, wdata_n;
  logic [3:0] last_addr, last_addr_n;
  logic       addr_valid, addr_valid_n;
  logic [1:0] code, code_n;
  logic [7:0] da_q, da_n;
  logic [1:0] ack_q, ack_n;
  logic [7:0] rd_q, rd_n;

  logic       grant_en;
  logic [1:0] gnt;

  assign grant_en = (state == IDLE);

  jt49_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.r1_req, bus.r0_req}),
    .en    (grant_en),
    .gnt   (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      sel        <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 4'd0;
      wdata_q    <= 8'h00;
      last_addr  <= 4'd0;
      addr_valid <= 1'b0;
      code       <= BUS_INACT;
      da_q       <= 8'h00;
      ack_q      <= 2'b00;
      rd_q       <= 8'h00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      we_q       <= we_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      last_addr  <= last_addr_n;
      addr_valid <= addr_valid_n;
      code       <= code_n;
      da_q       <= da_n;
      ack_q      <= ack_n;
      rd_q       <= rd_n;
    end
  end

  // code_n/da_n describe the bus during the *next* cycle, so every phase
  // drives its code on entry and on each non-final cycle.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sel_n        = sel;
    we_n         = we_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    last_addr_n  = last_addr;
    addr_valid_n = addr_valid;
    rd_n         = rd_q;
    code_n       = BUS_INACT;
    da_n         = 8'h00;

    case (state)
      IDLE: begin
        if (|gnt) begin
          sel_n   = gnt[1];
          we_n    = gnt[1] ? bus.r1_we    : bus.r0_we;
          addr_n  = gnt[1] ? bus.r1_addr  : bus.r0_addr;
          wdata_n = gnt[1] ? bus.r1_wdata : bus.r0_wdata;
          cnt_n   = PHASE_LOAD;
          if (SKIP_ADDR && addr_valid && (addr_n == last_addr)) begin
            state_n = DATA;
            code_n  = data_code(we_n);
            da_n    = data_bus(we_n, wdata_n);
          end else begin
            state_n = ADDR;
            code_n  = BUS_ADDR;
            da_n    = {4'h0, addr_n};
          end
        end
      end
      ADDR: begin
        if (cnt == 4'd0) begin
          state_n      = GAP;
          cnt_n        = GAP_LOAD;
          last_addr_n  = addr_q;
          addr_valid_n = 1'b1;
        end else begin
          cnt_n  = cnt - 4'd1;
          code_n = BUS_ADDR;
          da_n   = {4'h0, addr_q};
        end
      end
      GAP: begin
        if (cnt == 4'd0) begin
          state_n = DATA;
          cnt_n   = PHASE_LOAD;
          code_n  = data_code(we_q);
          da_n    = data_bus(we_q, wdata_q);
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DATA: begin
        if (cnt == 4'd0) begin
          state_n = REC;
          cnt_n   = GAP_LOAD;
          if (!we_q) begin
            rd_n = bus.psg_dout;
          end
        end else begin
          cnt_n  = cnt - 4'd1;
          code_n = data_code(we_q);
          da_n   = data_bus(we_q, wdata_q);
        end
      end
      REC: begin
        if (cnt == 4'd0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // ack is registered, so raise it when entering the final REC cycle
    ack_n = ((state_n == REC) && (cnt_n == 4'd0)) ? (sel_n ? 2'b10 : 2'b01) : 2'b00;
  end

  assign bus.bdir    = code[1];
  assign bus.bc1     = code[0];
  assign bus.da      = da_q;
  assign bus.r0_ack  = ack_q[0];
  assign bus.r1_ack  = ack_q[1];
  assign bus.rd_data = rd_q;
  assign bus.busy    = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_jt49_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_jt49_bus_arb : directed self-checking bench, two parameter sets
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jt49_bus_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jt49_bus_arb_if bus_a ();
  jt49_bus_arb_if bus_b ();

  jt49_bus_arb #(.PHASE_CYC(2), .GAP_CYC(1), .SKIP_ADDR(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  jt49_bus_arb #(.PHASE_CYC(1), .GAP_CYC(3), .SKIP_ADDR(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // minimal chip models: latch on 11, store on 10, dout from latched reg
  logic [7:0] regs_a [16];
  logic [7:0] regs_b [16];
  logic [3:0] lat_a, lat_b;

  always @(posedge clk) begin
    if (!rst_n) begin
      lat_a <= 4'd0;
      lat_b <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        regs_a[i] <= 8'h00;
        regs_b[i] <= 8'h00;
      end
    end else begin
      if (bus_a.bdir && bus_a.bc1) lat_a <= bus_a.da[3:0];
      else if (bus_a.bdir && !bus_a.bc1) regs_a[lat_a] <= bus_a.da;
      if (bus_b.bdir && bus_b.bc1) lat_b <= bus_b.da[3:0];
      else if (bus_b.bdir && !bus_b.bc1) regs_b[lat_b] <= bus_b.da;
    end
  end

  assign bus_a.psg_dout = regs_a[lat_a];
  assign bus_b.psg_dout = regs_b[lat_b];

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] tr_code [64];
  logic [7:0] tr_da   [64];
  logic [7:0] tr_rd   [64];
  logic       tr_busy [64];
  int         tr_n, ack0_at, ack1_at;

  task automatic set_rq(input int d, input int r, input bit q, input bit we,
                        input logic [3:0] a, input logic [7:0] w);
    if (d == 0) begin
      if (r == 0) begin bus_a.r0_req = q; bus_a.r0_we = we; bus_a.r0_addr = a; bus_a.r0_wdata = w; end
      else        begin bus_a.r1_req = q; bus_a.r1_we = we; bus_a.r1_addr = a; bus_a.r1_wdata = w; end
    end else begin
      if (r == 0) begin bus_b.r0_req = q; bus_b.r0_we = we; bus_b.r0_addr = a; bus_b.r0_wdata = w; end
      else        begin bus_b.r1_req = q; bus_b.r1_we = we; bus_b.r1_addr = a; bus_b.r1_wdata = w; end
    end
  endtask

  // Raise the requested reqs, record the bus each cycle until every ack is seen
  // (bounded), dropping each req in its ack cycle. scr corrupts r0 inputs after grant.
  task automatic do_bus(input int d,
                        input bit q0, input bit we0, input logic [3:0] a0, input logic [7:0] w0,
                        input bit q1, input bit we1, input logic [3:0] a1, input logic [7:0] w1,
                        input bit scr);
    bit p0, p1, s0, s1;
    @(negedge clk);
    ack0_at = -1;
    ack1_at = -1;
    tr_n    = 0;
    p0 = q0;
    p1 = q1;
    if (q0) set_rq(d, 0, 1'b1, we0, a0, w0);
    if (q1) set_rq(d, 1, 1'b1, we1, a1, w1);
    for (int k = 0; k < 64 && (p0 || p1); k++) begin
      @(negedge clk);
      if (d == 0) begin
        tr_code[k] = {bus_a.bdir, bus_a.bc1}; tr_da[k] = bus_a.da;
        tr_rd[k] = bus_a.rd_data; tr_busy[k] = bus_a.busy;
        s0 = bus_a.r0_ack; s1 = bus_a.r1_ack;
      end else begin
        tr_code[k] = {bus_b.bdir, bus_b.bc1}; tr_da[k] = bus_b.da;
        tr_rd[k] = bus_b.rd_data; tr_busy[k] = bus_b.busy;
        s0 = bus_b.r0_ack; s1 = bus_b.r1_ack;
      end
      tr_n = k + 1;
      if (scr && k == 0) set_rq(d, 0, 1'b1, ~we0, ~a0, ~w0);
      if (p0 && s0) begin ack0_at = k; p0 = 1'b0; set_rq(d, 0, 1'b0, 1'b0, 4'h0, 8'h00); end
      if (p1 && s1) begin ack1_at = k; p1 = 1'b0; set_rq(d, 1, 1'b0, 1'b0, 4'h0, 8'h00); end
    end
  endtask

  task automatic test_reset;
    logic [20:0] got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {bus_a.bdir, bus_a.bc1, bus_a.da, bus_a.r0_ack, bus_a.r1_ack, bus_a.rd_data, bus_a.busy};
    n_tests++;
    if (got !== 21'd0) begin n_fail++; $display("FAIL reset_a: got %h expected %h", got, 21'd0); end
    got = {bus_b.bdir, bus_b.bc1, bus_b.da, bus_b.r0_ack, bus_b.r1_ack, bus_b.rd_data, bus_b.busy};
    n_tests++;
    if (got !== 21'd0) begin n_fail++; $display("FAIL reset_b: got %h expected %h", got, 21'd0); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus_a.busy, bus_a.bdir, bus_a.bc1} !== 3'b000) begin
      n_fail++; $display("FAIL idle_no_req: got %b expected 000", {bus_a.busy, bus_a.bdir, bus_a.bc1});
    end
  endtask

  task automatic test_write_full;
    logic [1:0] ec [6];
    ec = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00};
    do_bus(0, 1'b1, 1'b1, 4'h7, 8'h38, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (tr_code[i] !== ec[i]) begin n_fail++; $display("FAIL wr_full_code[%0d]: got %b expected %b", i, tr_code[i], ec[i]); end
    end
    n_tests++;
    if ({tr_da[0], tr_da[1]} !== 16'h0707) begin n_fail++; $display("FAIL wr_full_addr_da: got %h expected 0707", {tr_da[0], tr_da[1]}); end
    n_tests++;
    if ({tr_da[3], tr_da[4]} !== 16'h3838) begin n_fail++; $display("FAIL wr_full_data_da: got %h expected 3838", {tr_da[3], tr_da[4]}); end
    n_tests++;
    if (ack0_at !== 5 || ack1_at !== -1) begin n_fail++; $display("FAIL wr_full_ack: got %0d/%0d expected 5/-1", ack0_at, ack1_at); end
    n_tests++;
    if (tr_busy[5] !== 1'b1) begin n_fail++; $display("FAIL wr_full_busy_ack: got %b expected 1", tr_busy[5]); end
    n_tests++;
    if (regs_a[7] !== 8'h38) begin n_fail++; $display("FAIL wr_full_mixer: got %h expected 38", regs_a[7]); end
  endtask

  task automatic test_skip_addr;
    do_bus(0, 1'b1, 1'b1, 4'h7, 8'h11, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    n_tests++;
    if ({tr_code[0], tr_code[1], tr_code[2]} !== 6'b10_10_00) begin
      n_fail++; $display("FAIL skip_code: got %b expected 101000", {tr_code[0], tr_code[1], tr_code[2]});
    end
    n_tests++;
    if (ack0_at !== 2) begin n_fail++; $display("FAIL skip_latency: got %0d expected 2", ack0_at); end
    n_tests++;
    if ({tr_da[0], tr_da[1]} !== 16'h1111) begin n_fail++; $display("FAIL skip_da: got %h expected 1111", {tr_da[0], tr_da[1]}); end
    n_tests++;
    if (regs_a[7] !== 8'h11) begin n_fail++; $display("FAIL skip_reg: got %h expected 11", regs_a[7]); end
  endtask

  task automatic test_rr;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_bus(0, 1'b1, 1'b1, 4'h3, 8'hA3, 1'b1, 1'b1, 4'h5, 8'hB5, 1'b0);
    n_tests++;
    if (ack0_at !== 5 || ack1_at !== 12) begin n_fail++; $display("FAIL rr_first: got %0d/%0d expected 5/12", ack0_at, ack1_at); end
    n_tests++;
    if ({tr_busy[6], tr_code[7], tr_da[7]} !== {1'b0, 2'b11, 8'h05}) begin
      n_fail++; $display("FAIL rr_r1_addr: got %h expected %h", {tr_busy[6], tr_code[7], tr_da[7]}, {1'b0, 2'b11, 8'h05});
    end
    n_tests++;
    if ({regs_a[3], regs_a[5]} !== 16'hA3B5) begin n_fail++; $display("FAIL rr_regs: got %h expected a3b5", {regs_a[3], regs_a[5]}); end
    do_bus(0, 1'b1, 1'b1, 4'h3, 8'hE3, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    n_tests++;
    if (ack0_at !== 5) begin n_fail++; $display("FAIL rr_solo: got %0d expected 5", ack0_at); end
    do_bus(0, 1'b1, 1'b1, 4'h2, 8'hC2, 1'b1, 1'b1, 4'h4, 8'hD4, 1'b0);
    n_tests++;
    if (ack1_at !== 5 || ack0_at !== 12) begin n_fail++; $display("FAIL rr_alt: got r1 %0d r0 %0d expected 5/12", ack1_at, ack0_at); end
    n_tests++;
    if (tr_da[0] !== 8'h04) begin n_fail++; $display("FAIL rr_alt_addr: got %h expected 04", tr_da[0]); end
  endtask

  task automatic test_read;
    do_bus(0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h0, 8'h5A, 1'b0);
    n_tests++;
    if (ack1_at !== 5) begin n_fail++; $display("FAIL rd_prewrite: got %0d expected 5", ack1_at); end
    do_bus(0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 8'hFF, 1'b0);
    n_tests++;
    if ({tr_code[0], tr_code[1], tr_code[2]} !== 6'b01_01_00) begin
      n_fail++; $display("FAIL rd_code: got %b expected 010100", {tr_code[0], tr_code[1], tr_code[2]});
    end
    n_tests++;
    if ({tr_da[0], tr_da[1]} !== 16'h0000) begin n_fail++; $display("FAIL rd_da: got %h expected 0000", {tr_da[0], tr_da[1]}); end
    n_tests++;
    if (ack1_at !== 2) begin n_fail++; $display("FAIL rd_ack: got %0d expected 2", ack1_at); end
    n_tests++;
    if ({tr_rd[1], tr_rd[2]} !== 16'h005A) begin n_fail++; $display("FAIL rd_capture: got %h expected 005a", {tr_rd[1], tr_rd[2]}); end
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus_a.rd_data !== 8'h5A) begin n_fail++; $display("FAIL rd_hold: got %h expected 5a", bus_a.rd_data); end
  endtask

  task automatic test_reset_mid;
    int acks;
    @(negedge clk);
    set_rq(0, 0, 1'b1, 1'b1, 4'h9, 8'h99);
    repeat (4) @(negedge clk);
    n_tests++;
    if ({bus_a.bdir, bus_a.bc1} !== 2'b10) begin n_fail++; $display("FAIL mid_in_data: got %b expected 10", {bus_a.bdir, bus_a.bc1}); end
    rst_n = 1'b0;
    set_rq(0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    n_tests++;
    if ({bus_a.bdir, bus_a.bc1, bus_a.busy, bus_a.r0_ack} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_abort: got %b expected 0000", {bus_a.bdir, bus_a.bc1, bus_a.busy, bus_a.r0_ack});
    end
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_a.r0_ack) acks++;
    end
    n_tests++;
    if (acks !== 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d expected 0", acks); end
    do_bus(0, 1'b1, 1'b1, 4'h9, 8'h77, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    n_tests++;
    if (tr_code[0] !== 2'b11 || ack0_at !== 5) begin
      n_fail++; $display("FAIL mid_readdr: got code %b ack %0d expected 11/5", tr_code[0], ack0_at);
    end
    n_tests++;
    if (regs_a[9] !== 8'h77) begin n_fail++; $display("FAIL mid_reg: got %h expected 77", regs_a[9]); end
  endtask

  task automatic test_timing;
    logic [1:0] ec [8];
    ec = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    do_bus(1, 1'b1, 1'b1, 4'h6, 8'h66, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (tr_code[i] !== ec[i]) begin n_fail++; $display("FAIL tim_code[%0d]: got %b expected %b", i, tr_code[i], ec[i]); end
    end
    n_tests++;
    if ({tr_da[0], tr_da[4]} !== 16'h0666) begin n_fail++; $display("FAIL tim_da: got %h expected 0666", {tr_da[0], tr_da[4]}); end
    n_tests++;
    if (ack0_at !== 7) begin n_fail++; $display("FAIL tim_wr_ack: got %0d expected 7", ack0_at); end
    do_bus(1, 1'b1, 1'b0, 4'h6, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
    n_tests++;
    if ({tr_code[0], tr_code[1], tr_code[2], tr_code[3]} !== 8'b01_00_00_00) begin
      n_fail++; $display("FAIL tim_rd_code: got %b expected 01000000", {tr_code[0], tr_code[1], tr_code[2], tr_code[3]});
    end
    n_tests++;
    if (ack0_at !== 3 || tr_rd[3] !== 8'h66) begin
      n_fail++; $display("FAIL tim_rd: got ack %0d data %h expected 3/66", ack0_at, tr_rd[3]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_rq(0, 0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_rq(0, 1, 1'b0, 1'b0, 4'h0, 8'h00);
    set_rq(1, 0, 1'b0, 1'b0, 4'h0, 8'h00);
    set_rq(1, 1, 1'b0, 1'b0, 4'h0, 8'h00);
    test_reset;
    test_write_full;
    test_skip_addr;
    test_rr;
    test_read;
    test_reset_mid;
    test_timing;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire

// File: doc/jt49_bus_arb.md
Name: jt49_bus_arb

Overview:
- Sequences and shares one AY-3-8910-style BDIR/BC1/DA bus between two requesters, e.g. CPU port and music-player engine.
- Turns each register read/write request into the chip's bus-cycle sequence: latch address, inactive gap, write or read strobe, recovery.
- Sits directly in front of jt49_bus; its bdir/bc1/da outputs drive that block's bdir/bc1/din, and jt49_bus dout returns on psg_dout.

Parameters:
- PHASE_CYC, 2, clk cycles each active phase (address latch, write, read) is held; legal range 1..15.
- GAP_CYC, 1, inactive (00) cycles between the address phase and the data phase, and after the data phase (recovery); legal range 1..15.
- SKIP_ADDR, 1, when 1, the address phase and its gap are omitted if the target register equals the last latched register.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- r0_req  in  1  requester 0 transfer request, held until r0_ack
- r0_we  in  1  requester 0: 1 = write, 0 = read
- r0_addr  in  4  requester 0 register index
- r0_wdata  in  8  requester 0 write data
- r0_ack  out  1  one-cycle completion pulse to requester 0
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack: same as above, for requester 1
- rd_data  out  8  data captured by the last read; valid from the ack cycle until the next read completes
- busy  out  1  high while any transfer is in progress (state != IDLE)
- bdir  out  1  to jt49_bus bdir
- bc1  out  1  to jt49_bus bc1
- da  out  8  to jt49_bus din; {4'h0, addr} during the address phase, wdata during the write phase
- psg_dout  in  8  from jt49_bus dout

Behaviour:
- Reset (synchronous): state IDLE; bdir=0, bc1=0, da=0, r0_ack=0, r1_ack=0, rd_data=0, busy=0, rr_ptr=0, addr_valid=0. Reset mid-transfer abandons the transfer with no ack; the bus shows 00 in the cycle after the reset edge.
- All bus outputs are registered. Each phase holds its {bdir,bc1} code constant for exactly its cycle count.
- Arbitration, in IDLE only:
  - A single requester with req=1 is granted.
  - If both requesters are high, grant the one selected by rr_ptr; on every grant, rr_ptr is set to the other requester.
  - At grant, that requester's we, addr and wdata are captured; later changes to its inputs are ignored until ack.
- State machine:
  - IDLE -> ADDR on grant. If SKIP_ADDR=1, addr_valid=1 and the captured addr equals last_addr, go directly IDLE -> DATA.
  - ADDR: {bdir,bc1}=11, da={4'h0,addr}, PHASE_CYC cycles. On exit, last_addr<=addr and addr_valid<=1. Next state GAP.
  - GAP: {bdir,bc1}=00, GAP_CYC cycles. Next state DATA.
  - DATA, write: {bdir,bc1}=10, da=wdata, PHASE_CYC cycles.
  - DATA, read: {bdir,bc1}=01, da=0, PHASE_CYC cycles; rd_data<=psg_dout on the last cycle of the phase.
  - DATA -> REC.
  - REC: {bdir,bc1}=00, GAP_CYC cycles. On the final cycle, pulse the granted requester's ack for 1 cycle and return to IDLE.
- A new grant can occur in the cycle after the ack pulse; a requester still showing req at that point is treated as a new request.
- Full-sequence latency from grant to ack, with PHASE_CYC=2 and GAP_CYC=1:
  - With address phase: ADDR 2, GAP 1, DATA 2, REC 1 = 6 cycles plus the grant cycle.
  - With address skipped: 3 cycles plus the grant cycle.
- One phase counter of 4 bits: loaded with (length-1) on phase entry, decremented each cycle, phase exits at 0. There is no other counter.
- Register indices are 4 bits, so da[7:4]=0 during the address phase and jt49's chip select is always enabled.
- Requests must stay high until ack; a req dropped after grant does not cancel the transfer.
- busy=1 from the cycle after grant through the ack cycle.

Decomposition:
- Shared package jt49_pkg holds:
  - bus codes BUS_INACT=2'b00, BUS_READ=2'b01, BUS_WRITE=2'b10, BUS_ADDR=2'b11;
  - FSM state encoding IDLE/ADDR/GAP/DATA/REC.
- Natural sub-module jt49_rr_arb2: 2-way round-robin arbiter with rr_ptr, grant vector and a grant-enable input. The phase counter stays inline.

Test Plan:
- r0 write addr=7 wdata=8'h38 from reset -> bus sequence 11/da=07 (2 cycles), 00 (1), 10/da=38 (2), 00 (1), r0_ack pulse; the jt49 mixer register reads back 8'h38.
- r0 write to reg 7 again immediately with SKIP_ADDR=1 -> no 11 phase, sequence 10 (2 cycles), 00 (1), ack 3 cycles after grant.
- r0 and r1 both request in the same cycle from reset -> r0 served first, r1 served next with a fresh address phase; repeat both requests -> r1 served first (rr alternation).
- r1 read reg 0 after writing 8'h5A to it -> bus shows 01 for 2 cycles, rd_data=8'h5A at r1_ack, and rd_data holds that value afterwards.
- rst_n low during the DATA phase of a write -> bus shows 00 in the next cycle, no ack; the following write to the same reg repeats the address phase (addr_valid was cleared).
- PHASE_CYC=1, GAP_CYC=3 -> each 11/10/01 phase lasts exactly 1 cycle, each 00 gap lasts exactly 3 cycles.
